fifo_st_to_mm_csr: RTL and testbench

FIFO_ST_TO_MM_CSR -- requirements
Module: fifo_st_to_mm_csr

---
 rtl/fifo_st_to_mm_csr.sv | 134 +++++++++++++
 tb/tb_fifo_st_to_mm_csr.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_st_to_mm_csr.sv
// Streaming-sink FIFO drained through a small Avalon-MM CSR window.
// Address 0 pops, 1 reads count, 2 is status/control, 3 is build info.
module fifo_st_to_mm_csr #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH_LOG2   = 8,
  parameter int unsigned AFULL_THRESH = 192,
  parameter int unsigned BACKPRESSURE = 0
) (
  input  logic                  wrclock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] avalonst_sink_data,
  input  logic                  avalonst_sink_valid,
  output logic                  avalonst_sink_ready,
  input  logic [1:0]            avalonmm_read_slave_address,
  input  logic                  avalonmm_read_slave_read,
  input  logic                  avalonmm_read_slave_write,
  input  logic [31:0]           avalonmm_read_slave_writedata,
  output logic [31:0]           avalonmm_read_slave_readdata,
  output logic                  irq
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_AFULL = CW'(AFULL_THRESH);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic [15:0]           drop_q, drop_d;
  logic [31:0]           rdata_q, rdata_d;

  logic empty, full, almost_full;
  logic pop_req, clear, flush, push, pop, drop, under;
  logic unused_wdata;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_FULL);
  assign almost_full = (count_q >= CNT_AFULL);

  assign pop_req = avalonmm_read_slave_read && (avalonmm_read_slave_address == 2'd0);
  assign clear   = avalonmm_read_slave_write && (avalonmm_read_slave_address == 2'd2) &&
                   avalonmm_read_slave_writedata[0];
  assign flush   = avalonmm_read_slave_write && (avalonmm_read_slave_address == 2'd2) &&
                   avalonmm_read_slave_writedata[1];

  // A flush swallows any same-cycle traffic without recording it as an event.
  assign push  = avalonst_sink_valid && !full && !flush;
  assign pop   = pop_req && !empty && !flush;
  assign drop  = (BACKPRESSURE == 0) && avalonst_sink_valid && full && !flush;
  assign under = pop_req && empty && !flush;

  assign unused_wdata = ^avalonmm_read_slave_writedata[31:2];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    drop_d      = drop_q;
    rdata_d     = '0;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // New events take priority over a clear issued in the same cycle.
    if (clear) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      drop_d      = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (clear)                drop_d = 16'd1;
      else if (drop_q != '1)    drop_d = drop_q + 16'd1;
    end
    if (under) underflow_d = 1'b1;

    if (avalonmm_read_slave_read) begin
      unique case (avalonmm_read_slave_address)
        2'd0: rdata_d = pop ? 32'(mem[rd_ptr_q]) : 32'd0;
        2'd1: rdata_d = 32'(count_q);
        2'd2: rdata_d = {drop_q, 11'd0, underflow_q, overflow_q, almost_full, full, empty};
        2'd3: rdata_d = {15'd0, 1'(BACKPRESSURE), 8'(DATA_WIDTH), 8'(DEPTH_LOG2)};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_q      <= '0;
      rdata_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      drop_q      <= drop_d;
      rdata_q     <= rdata_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge wrclock) begin
    if (push && reset_n) mem[wr_ptr_q] <= avalonst_sink_data;
  end

  assign avalonst_sink_ready          = (BACKPRESSURE != 0) ? !full : 1'b1;
  assign avalonmm_read_slave_readdata = rdata_q;
  assign irq                          = almost_full | overflow_q;

endmodule

// File: tb/tb_fifo_st_to_mm_csr.sv
// Directed bench: one drop-mode instance (index 0) and one backpressure instance (index 1).
module tb_fifo_st_to_mm_csr;

  logic        wrclock = 1'b0;
  logic        reset_n;
  logic [31:0] sdata;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        valid [2];
  logic        rd    [2];
  logic        wr    [2];
  logic        ready [2];
  logic        irq_o [2];
  logic [31:0] rdata [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 wrclock = ~wrclock;

  fifo_st_to_mm_csr #(.BACKPRESSURE(0)) dut (
    .wrclock                       (wrclock),
    .reset_n                       (reset_n),
    .avalonst_sink_data            (sdata),
    .avalonst_sink_valid           (valid[0]),
    .avalonst_sink_ready           (ready[0]),
    .avalonmm_read_slave_address   (addr),
    .avalonmm_read_slave_read      (rd[0]),
    .avalonmm_read_slave_write     (wr[0]),
    .avalonmm_read_slave_writedata (wdata),
    .avalonmm_read_slave_readdata  (rdata[0]),
    .irq                           (irq_o[0])
  );

  fifo_st_to_mm_csr #(.BACKPRESSURE(1)) dut_bp (
    .wrclock                       (wrclock),
    .reset_n                       (reset_n),
    .avalonst_sink_data            (sdata),
    .avalonst_sink_valid           (valid[1]),
    .avalonst_sink_ready           (ready[1]),
    .avalonmm_read_slave_address   (addr),
    .avalonmm_read_slave_read      (rd[1]),
    .avalonmm_read_slave_write     (wr[1]),
    .avalonmm_read_slave_writedata (wdata),
    .avalonmm_read_slave_readdata  (rdata[1]),
    .irq                           (irq_o[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge wrclock);
    #1;
  endtask

  task automatic push(input int s, input logic [31:0] d);
    sdata    = d;
    valid[s] = 1'b1;
    cyc();
    valid[s] = 1'b0;
  endtask

  task automatic csr_rd(input int s, input logic [1:0] a, output logic [31:0] d);
    addr  = a;
    rd[s] = 1'b1;
    cyc();
    rd[s] = 1'b0;
    d     = rdata[s];
  endtask

  task automatic csr_wr(input int s, input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr[s] = 1'b1;
    cyc();
    wr[s] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    reset_n = 1'b0;
    sdata = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
    end
    #3;
    check_eq("reset_readdata", rdata[0], 32'h0);
    check_eq("reset_irq", 32'(irq_o[0]), 32'h0);
    check_eq("reset_ready", 32'(ready[1]), 32'h1);
    valid[0] = 1'b1;
    repeat (2) @(posedge wrclock);
    valid[0] = 1'b0;
    @(negedge wrclock);
    reset_n = 1'b1;
    cyc();

    csr_rd(0, 2'd1, d); check_eq("count_after_reset", d, 32'h0);
    csr_rd(0, 2'd2, d); check_eq("status_after_reset", d, 32'h1);
    csr_rd(0, 2'd3, d); check_eq("info_drop", d, 32'h0000_2008);
    csr_rd(1, 2'd3, d); check_eq("info_bp", d, 32'h0001_2008);

    // Basic ordering and read latency
    push(0, 32'h11); push(0, 32'h22); push(0, 32'h33);
    csr_rd(0, 2'd1, d); check_eq("count3", d, 32'h3);
    csr_rd(0, 2'd0, d); check_eq("pop_11", d, 32'h11);
    csr_rd(0, 2'd0, d); check_eq("pop_22", d, 32'h22);
    csr_rd(0, 2'd0, d); check_eq("pop_33", d, 32'h33);
    cyc();              check_eq("readdata_idle", rdata[0], 32'h0);
    csr_rd(0, 2'd1, d); check_eq("count0", d, 32'h0);

    // Underflow and clear
    csr_rd(0, 2'd0, d); check_eq("underflow_data", d, 32'h0);
    csr_rd(0, 2'd2, d); check_eq("underflow_status", d, 32'h11);
    csr_wr(0, 2'd2, 32'h1);
    csr_rd(0, 2'd2, d); check_eq("clear_status", d, 32'h1);

    // Overfill: 260 pushes, 4 dropped
    for (int i = 0; i < 260; i++) push(0, 32'h100 + 32'(i));
    csr_rd(0, 2'd2, d); check_eq("overfill_status", d, 32'h0004_000E);
    csr_rd(0, 2'd1, d); check_eq("overfill_count", d, 32'h100);
    check_eq("overfill_irq", 32'(irq_o[0]), 32'h1);

    // Overflow in the same cycle as clear: event wins
    addr = 2'd2; wdata = 32'h1; wr[0] = 1'b1; sdata = 32'hBEEF; valid[0] = 1'b1;
    cyc();
    wr[0] = 1'b0; valid[0] = 1'b0;
    csr_rd(0, 2'd2, d); check_eq("clear_vs_overflow", d, 32'h0001_000E);

    // Full FIFO: pop with concurrent valid
    addr = 2'd0; rd[0] = 1'b1; sdata = 32'hDEAD; valid[0] = 1'b1;
    cyc();
    rd[0] = 1'b0; valid[0] = 1'b0;
    check_eq("full_pop_data", rdata[0], 32'h100);
    csr_rd(0, 2'd1, d); check_eq("full_pop_count", d, 32'hFF);
    csr_rd(0, 2'd2, d); check_eq("full_pop_status", d, 32'h0002_000C);
    csr_rd(0, 2'd0, d); check_eq("next_oldest", d, 32'h101);

    // Asynchronous reset with readdata and irq active
    csr_rd(0, 2'd1, d); check_eq("pre_reset_count", d, 32'hFE);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_readdata", rdata[0], 32'h0);
    check_eq("async_irq", 32'(irq_o[0]), 32'h0);
    check_eq("async_ready", 32'(ready[0]), 32'h1);
    @(negedge wrclock);
    reset_n = 1'b1;
    cyc();
    csr_rd(0, 2'd1, d); check_eq("post_reset_count", d, 32'h0);
    csr_rd(0, 2'd0, d); check_eq("post_reset_pop", d, 32'h0);
    csr_rd(0, 2'd2, d); check_eq("post_reset_status", d, 32'h11);

    // Clear+flush with count 10 and a concurrent push
    for (int i = 0; i < 10; i++) push(0, 32'hA0 + 32'(i));
    csr_rd(0, 2'd1, d); check_eq("count10", d, 32'hA);
    addr = 2'd2; wdata = 32'h3; wr[0] = 1'b1; sdata = 32'hBB; valid[0] = 1'b1;
    cyc();
    wr[0] = 1'b0; valid[0] = 1'b0;
    csr_rd(0, 2'd1, d); check_eq("flush_count", d, 32'h0);
    csr_rd(0, 2'd2, d); check_eq("flush_status", d, 32'h1);
    csr_rd(0, 2'd0, d); check_eq("flush_push_absent", d, 32'h0);

    // Backpressure instance
    for (int i = 0; i < 256; i++) push(1, 32'h100 + 32'(i));
    check_eq("bp_ready_full", 32'(ready[1]), 32'h0);
    push(1, 32'h999);
    csr_rd(1, 2'd2, d); check_eq("bp_status_full", d, 32'h6);
    check_eq("bp_irq", 32'(irq_o[1]), 32'h1);
    csr_rd(1, 2'd0, d); check_eq("bp_pop", d, 32'h100);
    check_eq("bp_ready_after_pop", 32'(ready[1]), 32'h1);
    csr_rd(1, 2'd2, d); check_eq("bp_status_after", d, 32'h4);
    csr_rd(1, 2'd1, d); check_eq("bp_count", d, 32'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
